// File: rtl/h_downscale_2to1.sv
// Horizontal 2:1 downscaler: emits one pixel per input pair (SAMPLE or rounded AVERAGE)
// with sync signals forwarded one clock late.
module h_downscale_2to1 #(
   parameter int DW    = 10,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_vsync,
   input  logic             i_hsync,
   input  logic             i_de,
   input  logic [DW-1:0]    i_r_data,
   input  logic [DW-1:0]    i_g_data,
   input  logic [DW-1:0]    i_b_data,
   input  logic             i_mode,
   output logic             o_vsync,
   output logic             o_hsync,
   output logic             o_de,
   output logic [DW-1:0]    o_r_data,
   output logic [DW-1:0]    o_g_data,
   output logic [DW-1:0]    o_b_data,
   output logic [CNT_W-1:0] o_line_cnt
);

   localparam int NC = 3;

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t                 state, state_nxt;
   logic [NC-1:0][DW-1:0]  in_px, hold_q, hold_nxt, avg_px, rgb_q, rgb_nxt;
   logic                   mode_q, mode_nxt, de_q, de_nxt, prev_de, vs_fall;
   logic [CNT_W-1:0]       cnt_q, cnt_nxt;

   assign in_px[2] = i_r_data;
   assign in_px[1] = i_g_data;
   assign in_px[0] = i_b_data;

   // One extra bit holds hold+in+1 without overflow; dropping the LSB rounds half up.
   generate
      for (genvar c = 0; c < NC; c++) begin : g_avg
         logic [DW:0] sum;
         assign sum       = {1'b0, hold_q[c]} + {1'b0, in_px[c]} + (DW+1)'(1);
         assign avg_px[c] = sum[DW:1];
      end
   endgenerate

   // o_vsync is i_vsync one clock ago, so it doubles as the edge-detect history.
   assign vs_fall = o_vsync & ~i_vsync;

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_q;
      mode_nxt  = mode_q;
      cnt_nxt   = cnt_q;
      de_nxt    = 1'b0;
      rgb_nxt   = '0;
      if (vs_fall) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (i_de) begin
                  hold_nxt = in_px;
                  if (!prev_de) begin
                     mode_nxt = i_mode;
                     cnt_nxt  = '0;
                  end
                  state_nxt = HOLD;
               end
            end
            HOLD: begin
               // de low here means a lone trailing pixel: emit it unchanged.
               de_nxt    = 1'b1;
               rgb_nxt   = (i_de && mode_q) ? avg_px : hold_q;
               cnt_nxt   = cnt_q + CNT_W'(1);
               state_nxt = EMPTY;
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= EMPTY;
         hold_q  <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= '0;
         de_q    <= 1'b0;
         rgb_q   <= '0;
         prev_de <= 1'b0;
         o_vsync <= 1'b1;
         o_hsync <= 1'b1;
      end else begin
         state   <= state_nxt;
         hold_q  <= hold_nxt;
         mode_q  <= mode_nxt;
         cnt_q   <= cnt_nxt;
         de_q    <= de_nxt;
         rgb_q   <= rgb_nxt;
         prev_de <= i_de;
         o_vsync <= i_vsync;
         o_hsync <= i_hsync;
      end
   end

   assign o_de       = de_q;
   assign o_r_data   = rgb_q[2];
   assign o_g_data   = rgb_q[1];
   assign o_b_data   = rgb_q[0];
   assign o_line_cnt = cnt_q;

endmodule
